// File: rtl/spi_byte_shifter_if.sv
// Signal bundle between the SPI pin front end and its control-unit side.
// The master modport drives pins and control-unit inputs; the slave is the shifter.
interface spi_byte_shifter_if;
  logic       spi_clk;
  logic       spi_mosi;
  logic       chip_select;
  logic       write_shift_reg;
  logic [7:0] tx_data;
  logic       spi_miso;
  logic       byte_read;
  logic [7:0] rx_data;
  logic       chip_select_sync;
  logic       byte_aborted;

  modport master (
    output spi_clk, spi_mosi, chip_select, write_shift_reg, tx_data,
    input  spi_miso, byte_read, rx_data, chip_select_sync, byte_aborted
  );

  modport slave (
    input  spi_clk, spi_mosi, chip_select, write_shift_reg, tx_data,
    output spi_miso, byte_read, rx_data, chip_select_sync, byte_aborted
  );
endinterface

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 slave bit front end: pin synchronisers, byte assembly on spiClk rises
// and MSB-first serialisation of the loaded transmit byte on spiClk falls.
module spi_byte_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input logic              clk_i,
  input logic              rst_n_i,
  spi_byte_shifter_if.slave bus_io
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;

  logic       sclk_hist_q;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  // The top received bit is never read back before it lands in rx_data, so only 7 are kept.
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       byte_read_q, byte_read_d;
  logic       aborted_q, aborted_d;

  logic       sclk_s, mosi_s, cs_s;
  logic [7:0] rx_capture;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      assign sclk_sync_d[gi] = bus_io.spi_clk;
      assign mosi_sync_d[gi] = bus_io.spi_mosi;
      assign cs_sync_d[gi]   = bus_io.chip_select;
    end else begin : g_next
      assign sclk_sync_d[gi] = sclk_sync_q[gi-1];
      assign mosi_sync_d[gi] = mosi_sync_q[gi-1];
      assign cs_sync_d[gi]   = cs_sync_q[gi-1];
    end
  end

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign rx_capture = {rx_shift_q, mosi_s};

  assign rise_d    = sclk_s & ~sclk_hist_q;
  assign fall_d    = ~sclk_s & sclk_hist_q;
  // bit_cnt is forced to 0 while deselected, so non-zero here means CS just rose mid-byte.
  assign aborted_d = cs_s && (bit_cnt_q != 3'd0);

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    byte_read_d = byte_read_q;
    tx_shift_d  = tx_shift_q;

    if (cs_s) begin
      bit_cnt_d   = 3'd0;
      byte_read_d = 1'b0;
      rx_shift_d  = 7'd0;
    end else if (rise_q) begin
      rx_shift_d = rx_capture[6:0];
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_data_d   = rx_capture;
        byte_read_d = 1'b1;
      end else begin
        byte_read_d = 1'b0;
      end
    end

    // A fall right after a completed byte must not eat the freshly loaded MSB.
    if (bus_io.write_shift_reg) begin
      tx_shift_d = bus_io.tx_data;
    end else if (!cs_s && fall_q && (bit_cnt_q != 3'd0)) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_hist_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      tx_shift_q  <= 8'd0;
      rx_data_q   <= 8'd0;
      byte_read_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_hist_q <= sclk_s;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      byte_read_q <= byte_read_d;
      aborted_q   <= aborted_d;
    end
  end

  assign bus_io.spi_miso         = cs_s ? 1'b0 : tx_shift_q[7];
  assign bus_io.byte_read        = byte_read_q;
  assign bus_io.rx_data          = rx_data_q;
  assign bus_io.chip_select_sync = cs_s;
  assign bus_io.byte_aborted     = aborted_q;

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Bench acting as SPI master and control unit around spi_byte_shifter; expected
// bytes and MISO streams come from the frame contents, not from the DUT.
`timescale 1ns/1ps
module tb_spi_byte_shifter;

  logic clk;
  logic rst_n;
  spi_byte_shifter_if bus();

  spi_byte_shifter #(.SYNC_STAGES(2)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int abort_cycles = 0;
  int abort_pulses = 0;
  logic abort_prev = 1'b0;

  logic [7:0] frame_rx [5];
  logic [7:0] frame_tx [5];
  logic [7:0] last_rx;

  always @(negedge clk) begin
    if (rst_n && bus.byte_aborted) abort_cycles++;
    if (rst_n && bus.byte_aborted && !abort_prev) abort_pulses++;
    abort_prev = bus.byte_aborted;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte, MSB first, 16-clk spiClk period; optionally reload tx after byteRead.
  task automatic send_byte(input logic [7:0] b, input logic [7:0] reload_val,
                           input bit reload, output logic [7:0] miso_got);
    for (int i = 7; i >= 0; i--) begin
      bus.spi_mosi = b[i];
      repeat (8) tick();
      bus.spi_clk = 1'b1;
      miso_got[i] = bus.spi_miso;
      repeat (4) tick();
      chk("byte_read_level", bus.byte_read, (i == 0));
      if (i == 0) begin
        chk("rx_data", bus.rx_data, b);
        if (reload) begin
          bus.tx_data = reload_val;
          bus.write_shift_reg = 1'b1;
          tick();
          bus.write_shift_reg = 1'b0;
          repeat (3) tick();
        end else begin
          repeat (4) tick();
        end
      end else begin
        repeat (4) tick();
      end
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic run_frame(input int n);
    logic [7:0] got;
    int ab0;
    ab0 = abort_pulses;
    bus.chip_select = 1'b0;
    bus.tx_data = frame_tx[0];
    bus.write_shift_reg = 1'b1;
    tick();
    bus.write_shift_reg = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < n; k++) begin
      send_byte(frame_rx[k], frame_tx[k+1], (k < n - 1), got);
      chk("miso_byte", got, frame_tx[k]);
      $display("[TB] byte %0d: mosi 0x%02h miso 0x%02h (expect 0x%02h) rx 0x%02h",
               k, frame_rx[k], got, frame_tx[k], bus.rx_data);
    end
    repeat (4) tick();
    bus.chip_select = 1'b1;
    repeat (4) tick();
    chk("cs_sync_deselect", bus.chip_select_sync, 1'b1);
    chk("byte_read_cleared", bus.byte_read, 1'b0);
    chk("rx_hold", bus.rx_data, frame_rx[n-1]);
    chk("no_abort", abort_pulses, ab0);
    last_rx = frame_rx[n-1];
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] got;
    int ab0;
    rst_n = 1'b0;
    bus.spi_clk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.chip_select = 1'b1;
    bus.write_shift_reg = 1'b0;
    bus.tx_data = 8'h00;
    last_rx = 8'h00;

    // Reset held with pins toggling.
    for (int c = 0; c < 12; c++) begin
      bus.spi_clk = 1'($urandom);
      bus.spi_mosi = 1'($urandom);
      bus.chip_select = 1'($urandom);
      bus.write_shift_reg = 1'($urandom);
      bus.tx_data = 8'($urandom);
      tick();
    end
    chk("rst_miso", bus.spi_miso, 1'b0);
    chk("rst_byte_read", bus.byte_read, 1'b0);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_aborted", bus.byte_aborted, 1'b0);
    chk("rst_cs_sync", bus.chip_select_sync, 1'b1);
    bus.spi_clk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.chip_select = 1'b1;
    bus.write_shift_reg = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_cs_sync", bus.chip_select_sync, 1'b1);
    chk("post_rst_byte_read", bus.byte_read, 1'b0);

    // Single byte receive with a transmit byte.
    frame_rx[0] = 8'hA5; frame_tx[0] = 8'h3C;
    run_frame(1);

    // Back-to-back with reloads.
    frame_rx[0] = 8'h01; frame_rx[1] = 8'hFF; frame_rx[2] = 8'h80;
    frame_tx[0] = 8'h11; frame_tx[1] = 8'h22; frame_tx[2] = 8'h33;
    run_frame(3);

    // Abort after 5 bits.
    ab0 = abort_pulses;
    bus.chip_select = 1'b0;
    repeat (6) tick();
    for (int i = 7; i >= 3; i--) begin
      bus.spi_mosi = 1'($urandom);
      repeat (8) tick();
      bus.spi_clk = 1'b1;
      repeat (8) tick();
      bus.spi_clk = 1'b0;
    end
    repeat (4) tick();
    bus.chip_select = 1'b1;
    repeat (6) tick();
    chk("abort_pulse", abort_pulses, ab0 + 1);
    chk("abort_rx_hold", bus.rx_data, last_rx);
    chk("abort_byte_read", bus.byte_read, 1'b0);
    $display("[TB] abort after 5 bits: pulses %0d rx 0x%02h", abort_pulses - ab0, bus.rx_data);

    frame_rx[0] = 8'h5A; frame_tx[0] = 8'hC3;
    run_frame(1);

    // Collision: CS deassert together with the 8th rise.
    ab0 = abort_pulses;
    bus.chip_select = 1'b0;
    repeat (6) tick();
    for (int i = 7; i >= 0; i--) begin
      bus.spi_mosi = 1'($urandom);
      repeat (8) tick();
      bus.spi_clk = 1'b1;
      if (i == 0) bus.chip_select = 1'b1;
      repeat (8) tick();
      bus.spi_clk = 1'b0;
    end
    repeat (4) tick();
    chk("collision_no_byte_read", bus.byte_read, 1'b0);
    chk("collision_abort", abort_pulses, ab0 + 1);
    chk("collision_rx_hold", bus.rx_data, last_rx);
    $display("[TB] collision: pulses %0d rx 0x%02h", abort_pulses - ab0, bus.rx_data);

    // Randomised frames.
    for (int f = 0; f < 16; f++) begin
      int n;
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < 4; k++) begin
        frame_rx[k] = 8'($urandom);
        frame_tx[k] = 8'($urandom);
      end
      repeat (int'($urandom_range(1, 10))) tick();
      run_frame(n);
    end

    // Reset mid-byte.
    bus.chip_select = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 3; i++) begin
      bus.spi_mosi = 1'b1;
      repeat (8) tick();
      bus.spi_clk = 1'b1;
      repeat (8) tick();
      bus.spi_clk = 1'b0;
    end
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rx_data", bus.rx_data, 8'h00);
    chk("midrst_cs_sync", bus.chip_select_sync, 1'b1);
    chk("midrst_miso", bus.spi_miso, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("midrst_reselect", bus.chip_select_sync, 1'b0);
    chk("midrst_byte_read", bus.byte_read, 1'b0);
    bus.chip_select = 1'b1;
    repeat (4) tick();
    $display("[TB] reset mid-byte: rx 0x%02h", bus.rx_data);

    chk("abort_width", abort_cycles, abort_pulses);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
